// File: rtl/nibble_source.sv
// Framed LFSR nibble source with valid/ready output handshake.
// Emits FRAME_LEN nibbles per accepted start, then one DONE cycle.
module nibble_source #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic       pclk,
    input  logic       RESET_n,
    input  logic       start,
    input  logic       pReady,
    output logic [3:0] random_data,
    output logic       pValid,
    output logic       first,
    output logic       last,
    output logic       busy,
    output logic       done,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_t      r_state;
    logic [7:0]  r_idx;
    logic [15:0] r_lfsr;
    logic [7:0]  r_frame_cnt;
    logic        r_pvalid;
    logic        r_first;
    logic        r_last;
    logic        r_busy;
    logic        r_done;

    logic        w_xfer;
    logic        w_fb;
    logic        w_at_last;
    logic [7:0]  w_idx_inc;

    assign w_xfer    = r_pvalid & pReady;
    assign w_fb      = r_lfsr[15] ^ r_lfsr[13]
                     ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_at_last = (r_idx == LAST_IDX);
    assign w_idx_inc = r_idx + 8'd1;

    assign random_data = r_lfsr[3:0];
    assign pValid      = r_pvalid;
    assign first       = r_first;
    assign last        = r_last;
    assign busy        = r_busy;
    assign done        = r_done;
    assign frame_cnt   = r_frame_cnt;

    // LFSR: steps only on a transfer; a stuck-at-zero value reloads SEED
    always_ff @(posedge pclk) begin
        if (!RESET_n) begin
            r_lfsr <= SEED;
        end else if (r_lfsr == 16'h0000) begin
            r_lfsr <= SEED;
        end else if (w_xfer) begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    // Frame FSM with registered handshake and status outputs
    always_ff @(posedge pclk) begin
        if (!RESET_n) begin
            r_state     <= S_IDLE;
            r_idx       <= 8'd0;
            r_frame_cnt <= 8'd0;
            r_pvalid    <= 1'b0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state  <= S_SEND;
                        r_idx    <= 8'd0;
                        r_pvalid <= 1'b1;
                        r_first  <= 1'b1;
                        r_last   <= (LAST_IDX == 8'd0);
                        r_busy   <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (w_at_last) begin
                            r_state  <= S_DONE;
                            r_pvalid <= 1'b0;
                            r_first  <= 1'b0;
                            r_last   <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_idx   <= w_idx_inc;
                            r_first <= 1'b0;
                            r_last  <= (w_idx_inc == LAST_IDX);
                        end
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_pvalid <= 1'b0;
                    r_first  <= 1'b0;
                    r_last   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_source.sv
// Scoreboard bench for nibble_source: random ready stalls,
// back-to-back frames, mid-frame reset, counter wrap.
module tb_nibble_source;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int FL = 16;

    logic       pclk = 1'b0;
    logic       RESET_n;
    logic       start;
    logic       pReady;
    logic [3:0] random_data;
    logic       pValid;
    logic       first;
    logic       last;
    logic       busy;
    logic       done;
    logic [7:0] frame_cnt;

    nibble_source #(.SEED(SEED), .FRAME_LEN(FL)) dut (
        .pclk(pclk),
        .RESET_n(RESET_n),
        .start(start),
        .pReady(pReady),
        .random_data(random_data),
        .pValid(pValid),
        .first(first),
        .last(last),
        .busy(busy),
        .done(done),
        .frame_cnt(frame_cnt)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [3:0] d;
        logic       f;
        logic       l;
    } exp_t;

    exp_t       expq[$];
    logic [3:0] seen[$];
    logic [15:0] m_lfsr;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int xfers = 0;
    int gap = 0;
    bit after_frame = 0;
    bit gap_chk = 0;
    bit saw_last = 0;
    bit rnd_rdy = 0;
    bit arm_stall = 0;
    int stall_left = 0;

    bit         p_valid = 0;
    bit         p_ready = 0;
    logic [3:0] p_data;
    logic       p_first;
    logic       p_last;
    bit         p_done = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] step(logic [15:0] x);
        if (x == 16'h0) return SEED;
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    task automatic push_frame();
        exp_t e;
        for (int i = 0; i < FL; i++) begin
            e.d = m_lfsr[3:0];
            e.f = (i == 0);
            e.l = (i == FL - 1);
            expq.push_back(e);
            m_lfsr = step(m_lfsr);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Monitor: pops expected nibbles on each transfer
    always @(negedge pclk) begin
        exp_t e;
        if (!RESET_n) begin
            xfers = 0;
            gap = 0;
            after_frame = 0;
            p_valid = 0;
            p_done = 0;
        end else begin
            if (!pValid) begin
                chk("idle_first_last", {first, last}, 2'b00);
            end
            if (done) begin
                done_cnt++;
                chk("done_width", p_done, 0);
            end
            p_done = done;
            if (pValid) begin
                if (gap > 0 && gap_chk && after_frame)
                    chk("frame_gap", gap, 2);
                gap = 0;
                after_frame = 0;
                if (p_valid && !p_ready) begin
                    chk("stall_data", random_data, p_data);
                    chk("stall_first", first, p_first);
                    chk("stall_last", last, p_last);
                end
                if (pReady) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_xfer", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        chk("data", random_data, e.d);
                        chk("first", first, e.f);
                        chk("last", last, e.l);
                    end
                    seen.push_back(random_data);
                    xfers++;
                    if (last) begin
                        xfers = 0;
                        after_frame = 1;
                        saw_last = 1;
                    end
                end
            end else begin
                gap++;
            end
            p_valid = pValid;
            p_ready = pReady;
            p_data  = random_data;
            p_first = first;
            p_last  = last;
        end
    end

    // pReady driver: constant, random, or a forced 20-cycle stall at idx 7
    initial begin
        pReady = 1'b0;
        forever begin
            tick();
            if (stall_left > 0) begin
                pReady = 1'b0;
                stall_left--;
            end else if (arm_stall && pValid && xfers == 7) begin
                pReady = 1'b0;
                stall_left = 19;
                arm_stall = 0;
            end else if (rnd_rdy) begin
                pReady = 1'($urandom_range(0, 1));
            end else begin
                pReady = 1'b1;
            end
        end
    end

    task automatic wait_done(int target, int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge pclk);
            #1;
            n++;
        end
        chk("wait_done", done_cnt >= target, 1);
    endtask

    task automatic idle_chk(int fc);
        repeat (3) @(negedge pclk);
        chk("idle_busy", busy, 0);
        chk("frame_cnt", frame_cnt, fc);
        chk("queue_empty", expq.size(), 0);
    endtask

    task automatic reset_chk(string tag);
        chk({tag, "_pValid"}, pValid, 0);
        chk({tag, "_first"}, first, 0);
        chk({tag, "_last"}, last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
        chk({tag, "_data"}, random_data, 4'h1);
    endtask

    task automatic do_reset();
        RESET_n = 1'b0;
        start = 1'b0;
        expq.delete();
        m_lfsr = SEED;
        repeat (2) tick();
        @(negedge pclk);
        reset_chk("rst");
        tick();
        RESET_n = 1'b1;
        @(negedge pclk);
        reset_chk("post_rst");
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        push_frame();
        tick();
        start = 1'b0;
    endtask

    initial begin
        int base;
        int d0;
        int n;
        RESET_n = 1'b0;
        start = 1'b0;
        m_lfsr = SEED;

        // single frame, constant ready
        do_reset();
        base = seen.size();
        d0 = done_cnt;
        pulse_start();
        wait_done(d0 + 1, 200);
        idle_chk(1);
        chk("nib0", seen[base], 4'h1);
        chk("nib1", seen[base + 1], 4'h3);
        chk("frame_len", seen.size() - base, FL);

        // random stalls with a long stall at idx 7, same sequence
        do_reset();
        base = seen.size();
        d0 = done_cnt;
        rnd_rdy = 1;
        arm_stall = 1;
        pulse_start();
        wait_done(d0 + 1, 1000);
        idle_chk(1);
        chk("stall_nib0", seen[base], 4'h1);
        chk("stall_nib1", seen[base + 1], 4'h3);
        chk("stall_fired", arm_stall, 0);
        rnd_rdy = 0;

        // start held for three back-to-back frames
        do_reset();
        d0 = done_cnt;
        gap_chk = 1;
        start = 1'b1;
        repeat (3) push_frame();
        wait_done(d0 + 3, 300);
        tick();
        start = 1'b0;
        idle_chk(3);
        gap_chk = 0;

        // reset pulsed at idx 5
        do_reset();
        d0 = done_cnt;
        start = 1'b1;
        push_frame();
        tick();
        start = 1'b0;
        n = 0;
        while (!(pValid && xfers == 5) && n < 100) begin
            tick();
            n++;
        end
        chk("reach_idx5", xfers, 5);
        RESET_n = 1'b0;
        expq.delete();
        m_lfsr = SEED;
        @(posedge pclk);
        @(negedge pclk);
        chk("midrst_pValid", pValid, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        tick();
        RESET_n = 1'b1;
        repeat (3) tick();
        chk("midrst_no_done", done_cnt, d0);
        base = seen.size();
        pulse_start();
        wait_done(d0 + 1, 200);
        idle_chk(1);
        chk("midrst_nib0", seen[base], 4'h1);

        // start pulses during SEND and DONE are ignored
        do_reset();
        d0 = done_cnt;
        saw_last = 0;
        pulse_start();
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
        end
        n = 0;
        while (!saw_last && n < 200) begin
            tick();
            n++;
        end
        chk("saw_last", saw_last, 1);
        chk("in_done", done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("ignored_done_cnt", done_cnt - d0, 1);
        idle_chk(1);

        // 256 frames: frame counter wraps to 0
        do_reset();
        d0 = done_cnt;
        start = 1'b1;
        repeat (256) push_frame();
        wait_done(d0 + 255, 6000);
        n = 0;
        while (!pValid && n < 10) begin
            @(negedge pclk);
            n++;
        end
        chk("cnt_255", frame_cnt, 8'd255);
        wait_done(d0 + 256, 100);
        tick();
        start = 1'b0;
        idle_chk(0);
        chk("wrap_done_pulses", done_cnt - d0, 256);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
